mult_div_seq: RTL
=================

Name: mult_div_seq

Overview:
- Parametrised iterative multiply/divide unit; successor to the fixed 16-bit unsigned shift-add multiplier.
- Adds configurable width, signed/unsigned multiply, signed/unsigned restoring divide, MIPS-style Hi/Lo result pair, divide-by-zero flag, and synchronous reset.
- Sits beside the ALU in the MIPS datapath and serves MULT/MULTU/DIV/DIVU. The pipeline stalls on Idle=0.

Parameters:
W, 16, operand width in bits (W ≥ 4, even)
CW, 5, iteration counter width; must satisfy 2^CW > W

Ports:
Clk  in  1  clock; all state changes on the rising edge
Rst_n  in  1  synchronous reset, active-low, sampled on the Clk rising edge
St  in  1  start request; sampled only in IDLE
Op  in  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
OpA  in  W  multiplicand / dividend
OpB  in  W  multiplier / divisor
Idle  out  1  high while in IDLE (ready for St)
Done  out  1  one-cycle pulse; Hi/Lo/DivZero valid from this cycle
Hi  out  W  multiply: product[2W-1:W]; divide: remainder
Lo  out  W  multiply: product[W-1:0]; divide: quotient
DivZero  out  1  last completed divide had OpB==0; cleared by any completed multiply

Behaviour:
- Reset (Rst_n=0 at an edge), regardless of state:
  - state=IDLE, Hi=0, Lo=0, DivZero=0, Done=0, counter=0.
  - Reset mid-operation aborts the operation and discards partial results.
  - Rst_n has priority over St.
- States:
  - IDLE: Idle=1. On St=1, latch Op, OpA, OpB into internal registers and go to CALC. Operand changes after this edge are ignored.
  - CALC: the start edge latches operand magnitudes, the sign flags (for Op=01/11 and negative operand MSB), and counter=W. Each cycle performs one iteration and decrements the counter. After the W-th iteration, go to FIX.
  - FIX: apply sign correction and write Hi/Lo/DivZero. Go to DONE.
  - DONE: Done=1 for exactly one cycle, Idle=0. Next state is IDLE.
- Latency: St sampled at edge k; Done is high during the cycle after edge k+W+1; Idle returns high after edge k+W+2. Total operation is W+2 cycles; a back-to-back St is accepted at edge k+W+2.
- St while not IDLE: ignored. No queueing, no effect on the current operation.
- Hi/Lo hold their value from FIX until the next FIX or reset.
- Multiply:
  - Shift-add on magnitudes.
  - Signed: if exactly one operand is negative, {Hi,Lo} = two's-complement negation of the 2W-bit magnitude product.
  - Operand value −2^(W−1) uses magnitude 2^(W−1), held in a W-bit unsigned register.
- Divide:
  - Restoring, one quotient bit per cycle, on magnitudes.
  - Signed: quotient negated when operand signs differ; remainder takes the sign of the dividend; remainder magnitude < divisor magnitude.
  - Signed −2^(W−1) / −1: Lo = −2^(W−1) (wraps), Hi = 0, DivZero = 0.
- Divide by zero (OpB==0, Op=1x): still takes full latency. Lo = all ones, Hi = OpA unchanged, DivZero = 1, independent of signedness.
- Multiply by zero: Hi=Lo=0, normal latency. DivZero=0 after FIX.

Test Plan:
- W=16, MULTU 12×0, then 12×10, then 200×3, with St pulses spaced ≥18 cycles -> Lo=0/120/600, Hi=0 each time. Done pulses exactly 17 cycles after each St edge.
- W=16, MULTU 0xFFFF×0xFFFF -> Hi=0xFFFE, Lo=0x0001. The same operands with MULT (−1×−1) -> Hi=0x0000, Lo=0x0001. MULT −3×5 -> Hi=0xFFFF, Lo=0xFFF1.
- W=16, DIVU 100/7 -> Lo=14, Hi=2. DIV −7/2 -> Lo=0xFFFD, Hi=0xFFFF. DIV 0x8000/0xFFFF -> Lo=0x8000, Hi=0.
- W=16, DIVU 55/0 -> Lo=0xFFFF, Hi=55, DivZero=1. A following MULTU 2×3 -> Lo=6, DivZero=0.
- St re-asserted during CALC with different operands -> ignored; the first result completes unchanged. Rst_n=0 for one edge at iteration 8 of a multiply -> Idle=1, Hi=Lo=0, no Done pulse. A subsequent St runs normally.
- W=32 instance, MULTU 0xFFFFFFFF×2 -> Hi=1, Lo=0xFFFFFFFE, Done 33 cycles after St.

Source files
------------

// File: rtl/mult_div_seq_if.sv
// Handshake and result bus of the iterative multiply/divide unit.
// The datapath side connects through the master modport; the unit itself uses the slave modport.
interface mult_div_seq_if #(
    parameter int W = 16
) ();
    logic         St;
    logic [1:0]   Op;
    logic [W-1:0] OpA;
    logic [W-1:0] OpB;
    logic         Idle;
    logic         Done;
    logic [W-1:0] Hi;
    logic [W-1:0] Lo;
    logic         DivZero;

    modport master (
        output St, Op, OpA, OpB,
        input  Idle, Done, Hi, Lo, DivZero
    );

    modport slave (
        input  St, Op, OpA, OpB,
        output Idle, Done, Hi, Lo, DivZero
    );
endinterface

// File: rtl/mult_div_seq.sv
// Iterative W-bit multiply/divide unit for MULT/MULTU/DIV/DIVU with a MIPS-style Hi/Lo pair.
// Both operations run on operand magnitudes and apply sign correction in one fix-up cycle.
module mult_div_seq #(
    parameter int W  = 16,
    parameter int CW = 5
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    mult_div_seq_if.slave        bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           is_div_q, is_div_d;
    logic           neg_a_q, neg_a_d;
    logic           neg_b_q, neg_b_d;
    logic           bzero_q, bzero_d;
    logic [W-1:0]   opa_q, opa_d;
    logic [W-1:0]   bmag_q, bmag_d;
    logic [W:0]     rem_q, rem_d;
    logic [W-1:0]   quo_q, quo_d;
    logic [W-1:0]   hi_q, hi_d;
    logic [W-1:0]   lo_q, lo_d;
    logic           divzero_q, divzero_d;
    logic           done_q, done_d;
    logic           idle_q, idle_d;

    logic [W:0]     mul_sum_s;
    logic [W:0]     div_shift_s;
    logic [W:0]     div_diff_s;
    logic           div_ge_s;
    logic [2*W-1:0] prod_s;

    function automatic logic [W-1:0] neg_w(input logic [W-1:0] v);
        return ~v + {{(W-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [2*W-1:0] neg_2w(input logic [2*W-1:0] v);
        return ~v + {{(2*W-1){1'b0}}, 1'b1};
    endfunction

    assign bus.Idle    = idle_q;
    assign bus.Done    = done_q;
    assign bus.Hi      = hi_q;
    assign bus.Lo      = lo_q;
    assign bus.DivZero = divzero_q;

    // Next-state, iteration datapath and result fix-up.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_a_d   = neg_a_q;
        neg_b_d   = neg_b_q;
        bzero_d   = bzero_q;
        opa_d     = opa_q;
        bmag_d    = bmag_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        divzero_d = divzero_q;

        // Multiply adds into the upper half and shifts {acc, multiplier} right;
        // divide shifts {rem, dividend} left and keeps the difference when it fits.
        mul_sum_s   = rem_q + (quo_q[0] ? {1'b0, bmag_q} : {(W+1){1'b0}});
        div_shift_s = {rem_q[W-1:0], quo_q[W-1]};
        div_ge_s    = (div_shift_s >= {1'b0, bmag_q});
        div_diff_s  = div_shift_s - {1'b0, bmag_q};
        prod_s      = (neg_a_q ^ neg_b_q) ? neg_2w({rem_q[W-1:0], quo_q})
                                          : {rem_q[W-1:0], quo_q};

        case (state_q)
            S_IDLE: begin
                if (bus.St) begin
                    is_div_d = bus.Op[1];
                    neg_a_d  = bus.Op[0] & bus.OpA[W-1];
                    neg_b_d  = bus.Op[0] & bus.OpB[W-1];
                    bzero_d  = (bus.OpB == {W{1'b0}});
                    opa_d    = bus.OpA;
                    quo_d    = (bus.Op[0] & bus.OpA[W-1]) ? neg_w(bus.OpA) : bus.OpA;
                    bmag_d   = (bus.Op[0] & bus.OpB[W-1]) ? neg_w(bus.OpB) : bus.OpB;
                    rem_d    = {(W+1){1'b0}};
                    cnt_d    = CW'(W);
                    state_d  = S_CALC;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_CALC: begin
                if (is_div_q) begin
                    rem_d = div_ge_s ? div_diff_s : div_shift_s;
                    quo_d = {quo_q[W-2:0], div_ge_s};
                end else begin
                    rem_d = {1'b0, mul_sum_s[W:1]};
                    quo_d = {mul_sum_s[0], quo_q[W-1:1]};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_FIX;
                end else begin
                    state_d = S_CALC;
                end
            end
            S_FIX: begin
                if (!is_div_q) begin
                    hi_d      = prod_s[2*W-1:W];
                    lo_d      = prod_s[W-1:0];
                    divzero_d = 1'b0;
                end else if (bzero_q) begin
                    // Divide by zero reports the raw dividend, whatever the signedness.
                    hi_d      = opa_q;
                    lo_d      = {W{1'b1}};
                    divzero_d = 1'b1;
                end else begin
                    lo_d      = (neg_a_q ^ neg_b_q) ? neg_w(quo_q) : quo_q;
                    hi_d      = neg_a_q ? neg_w(rem_q[W-1:0]) : rem_q[W-1:0];
                    divzero_d = 1'b0;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        done_d = (state_d == S_DONE);
        idle_d = (state_d == S_IDLE);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= {CW{1'b0}};
            is_div_q  <= 1'b0;
            neg_a_q   <= 1'b0;
            neg_b_q   <= 1'b0;
            bzero_q   <= 1'b0;
            opa_q     <= {W{1'b0}};
            bmag_q    <= {W{1'b0}};
            rem_q     <= {(W+1){1'b0}};
            quo_q     <= {W{1'b0}};
            hi_q      <= {W{1'b0}};
            lo_q      <= {W{1'b0}};
            divzero_q <= 1'b0;
            done_q    <= 1'b0;
            idle_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_a_q   <= neg_a_d;
            neg_b_q   <= neg_b_d;
            bzero_q   <= bzero_d;
            opa_q     <= opa_d;
            bmag_q    <= bmag_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            divzero_q <= divzero_d;
            done_q    <= done_d;
            idle_q    <= idle_d;
        end
    end

endmodule
